// File: rtl/note_sequencer_if.sv
// note_sequencer_if: note-table programming bus between the MusicBox
// control logic (master) and note_sequencer (slave).
interface note_sequencer_if #(
  parameter int AW = 4
) ();
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [13:0]   cfg_freq;
  logic [9:0]    cfg_dur;
  logic          cfg_last;

  modport master (
    output cfg_we, cfg_addr, cfg_freq, cfg_dur, cfg_last
  );

  modport slave (
    input cfg_we, cfg_addr, cfg_freq, cfg_dur, cfg_last
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: plays a note table into the sine generator with a linear
// attack/release envelope. Optional glide feature: NOTE_SEQ_GLIDE_EN.
module note_sequencer #(
  parameter int DEPTH        = 16,
  parameter int TICKS_PER_MS = 32,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 8,
  parameter int ZERO_TIMEOUT = 64,
  parameter int GLIDE_STEP   = 16
) (
  input  logic                     CLK_32KHz,
  input  logic                     reset_n,
  note_sequencer_if.slave          cfg,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     gen_index_zero,
  output logic [13:0]              gen_frequency,
  output logic [7:0]               gen_amplitude,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] note_index,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int WW = $clog2(ZERO_TIMEOUT) + 1;

`ifdef NOTE_SEQ_GLIDE_EN
  localparam bit GLIDE = 1'b1;
`else
  localparam bit GLIDE = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_ATTACK,
    S_SUSTAIN, S_REST, S_RELEASE, S_NEXT
  } state_t;

  typedef struct packed {
    logic [13:0] freq;
    logic [9:0]  dur;
    logic        last;
  } slot_t;

  slot_t       tbl_q [DEPTH];
  slot_t       tbl_d [DEPTH];
  slot_t       slot;
  state_t      state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [13:0] freq_q, freq_d;
  logic [13:0] gfreq_q, gfreq_d;
  logic        last_q, last_d;
  logic [9:0]  rem_q, rem_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [WW-1:0] wz_q, wz_d;
  logic [7:0]  amp_q, amp_d;
  logic        done_q, done_d;
  logic        stopping_q, stopping_d;
  logic        relaunch_q, relaunch_d;

  logic        tick, expire, is_last, rel_zero;
  logic [8:0]  att_sum;
  logic [7:0]  rel_amp;
  logic [14:0] glide_up;
  state_t      end_state;

  assign slot     = tbl_q[ptr_q];
  assign tick     = (pre_q == '0);
  assign expire   = tick && (rem_q == 10'd1);
  assign is_last  = last_q || (ptr_q == AW'(DEPTH - 1));
  assign att_sum  = {1'b0, amp_q} + 9'(ATTACK_STEP);
  assign rel_amp  = ({1'b0, amp_q} > 9'(RELEASE_STEP)) ?
                    amp_q - 8'(RELEASE_STEP) : 8'd0;
  assign rel_zero = (rel_amp == 8'd0);
  assign glide_up = {1'b0, gfreq_q} + 15'(GLIDE_STEP);
  // With glide the envelope stays up between notes, except on the last.
  assign end_state = (GLIDE && !is_last) ? S_NEXT : S_RELEASE;

  always_comb begin
    tbl_d = tbl_q;
    if (cfg.cfg_we) begin
      tbl_d[cfg.cfg_addr] = {cfg.cfg_freq, cfg.cfg_dur, cfg.cfg_last};
    end
  end

  always_ff @(posedge CLK_32KHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      freq_q     <= '0;
      gfreq_q    <= '0;
      last_q     <= 1'b0;
      rem_q      <= '0;
      pre_q      <= '0;
      wz_q       <= '0;
      amp_q      <= '0;
      done_q     <= 1'b0;
      stopping_q <= 1'b0;
      relaunch_q <= 1'b0;
    end else begin
      tbl_q      <= tbl_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      freq_q     <= freq_d;
      gfreq_q    <= gfreq_d;
      last_q     <= last_d;
      rem_q      <= rem_d;
      pre_q      <= pre_d;
      wz_q       <= wz_d;
      amp_q      <= amp_d;
      done_q     <= done_d;
      stopping_q <= stopping_d;
      relaunch_q <= relaunch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start) state_d = S_LOAD;
      S_LOAD:
        if (GLIDE && amp_q != 8'd0 &&
            (slot.dur == '0 || slot.freq == '0)) state_d = S_RELEASE;
        else if (slot.dur == '0)  state_d = S_NEXT;
        else if (slot.freq == '0) state_d = S_REST;
        else if (GLIDE && amp_q != 8'd0) state_d = S_SUSTAIN;
        else state_d = S_WAIT;
      S_WAIT:
        if (gen_index_zero || wz_q == WW'(ZERO_TIMEOUT - 1))
          state_d = S_ATTACK;
      S_ATTACK:
        if (expire) state_d = end_state;
        else if (att_sum >= 9'd255) state_d = S_SUSTAIN;
      S_SUSTAIN:
        if (expire) state_d = end_state;
      S_REST:
        if (expire) state_d = S_NEXT;
      S_RELEASE:
        if (rel_zero) begin
          if (stopping_q)      state_d = S_IDLE;
          else if (relaunch_q) state_d = S_LOAD;
          else                 state_d = S_NEXT;
        end
      S_NEXT:
        if (is_last && !loop_en) state_d = S_IDLE;
        else state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      if (state_q == S_IDLE)   state_d = S_IDLE;
      else if (amp_q != 8'd0)  state_d = S_RELEASE;
      else                     state_d = S_IDLE;
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    freq_d     = freq_q;
    gfreq_d    = gfreq_q;
    last_d     = last_q;
    rem_d      = rem_q;
    pre_d      = PW'(TICKS_PER_MS - 1);
    wz_d       = '0;
    amp_d      = amp_q;
    stopping_d = (state_q != S_IDLE) && (stopping_q || stop);
    relaunch_d = (state_q == S_LOAD && state_d == S_RELEASE) ||
                 (state_q == S_RELEASE && relaunch_q);
    done_d     = (state_q == S_NEXT) && is_last && !loop_en && !stop;

    if (state_q == S_IDLE && state_d == S_LOAD) ptr_d = '0;
    if (state_q == S_NEXT && state_d == S_LOAD)
      ptr_d = is_last ? '0 : ptr_q + AW'(1);

    if (state_q == S_LOAD) begin
      freq_d = slot.freq;
      rem_d  = slot.dur;
      last_d = slot.last;
    end

    if (state_q == S_ATTACK || state_q == S_SUSTAIN ||
        state_q == S_REST) begin
      if (tick) rem_d = rem_q - 10'd1;
      else      pre_d = pre_q - PW'(1);
    end

    if (state_q == S_WAIT) begin
      wz_d = wz_q + WW'(1);
      if (state_d == S_ATTACK) gfreq_d = freq_q;
    end

    // Glide walks toward the target once per ms without overshooting.
    if (GLIDE && tick &&
        (state_q == S_ATTACK || state_q == S_SUSTAIN)) begin
      if (gfreq_q < freq_q)
        gfreq_d = (glide_up >= {1'b0, freq_q}) ? freq_q : glide_up[13:0];
      else if (gfreq_q > freq_q)
        gfreq_d = ({1'b0, gfreq_q} <= {1'b0, freq_q} + 15'(GLIDE_STEP)) ?
                  freq_q : gfreq_q - 14'(GLIDE_STEP);
    end

    unique case (state_q)
      S_WAIT:    amp_d = 8'd0;
      S_ATTACK:  amp_d = (att_sum > 9'd255) ? 8'd255 : att_sum[7:0];
      S_SUSTAIN: amp_d = 8'd255;
      S_RELEASE: amp_d = rel_amp;
      default:   amp_d = amp_q;
    endcase
  end

  always_comb begin
    gen_frequency = gfreq_q;
    gen_amplitude = amp_q;
    busy          = (state_q != S_IDLE);
    note_index    = ptr_q;
    done          = done_q;
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench; expected frequency/slot events are
// queued when notes are programmed and popped as the generator is retuned.
`timescale 1ns/1ps
module tb_note_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic loop_en = 1'b0;
  logic zero = 1'b0;
  logic [13:0]   gen_frequency;
  logic [7:0]    gen_amplitude;
  logic          busy;
  logic          done;
  logic [AW-1:0] note_index;

  note_sequencer_if #(.AW(AW)) cfg ();

  note_sequencer #(.DEPTH(DEPTH)) dut (
    .CLK_32KHz      (clk),
    .reset_n        (rst_n),
    .cfg            (cfg),
    .start          (start),
    .stop           (stop),
    .loop_en        (loop_en),
    .gen_index_zero (zero),
    .gen_frequency  (gen_frequency),
    .gen_amplitude  (gen_amplitude),
    .busy           (busy),
    .note_index     (note_index),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int freq;
    int idx;
  } ev_t;

  ev_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int ev_cnt = 0;
  logic [13:0] prev_f = '0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (done) done_cnt++;
    if (gen_frequency != prev_f && gen_frequency != 14'd0) begin
      ev_cnt++;
      if (sb.size() == 0) begin
        check("sb_unexpected", int'(gen_frequency), 0);
      end else begin
        e = sb.pop_front();
        check("sb_freq", int'(gen_frequency), e.freq);
        check("sb_idx", int'(note_index), e.idx);
      end
    end
    prev_f = gen_frequency;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    done_cnt = 0;
    ev_cnt = 0;
  endtask

  task automatic prog(input int a, input int f, input int d, input bit l);
    cfg.cfg_we   = 1'b1;
    cfg.cfg_addr = AW'(a);
    cfg.cfg_freq = 14'(f);
    cfg.cfg_dur  = 10'(d);
    cfg.cfg_last = l;
    tick(1);
    cfg.cfg_we   = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int n;
    n = 0;
    while (!done && n < lim) begin
      tick(1);
      n++;
    end
    check(tag, int'(done), 1);
  endtask

  initial begin
    int e;
    int n;
    int maxa;
    cfg.cfg_we   = 1'b0;
    cfg.cfg_addr = '0;
    cfg.cfg_freq = '0;
    cfg.cfg_dur  = '0;
    cfg.cfg_last = 1'b0;

    // single note: phase-zero retune, attack, sustain, release, done
    do_reset();
    check("rst_freq", int'(gen_frequency), 0);
    check("rst_amp", int'(gen_amplitude), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_idx", int'(note_index), 0);
    check("rst_done", int'(done), 0);
    prog(0, 440, 10, 1'b1);
    sb.push_back('{440, 0});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t1_busy", int'(busy), 1);
    tick(3);
    check("t1_wait_freq", int'(gen_frequency), 0);
    zero = 1'b1;
    tick(1);
    zero = 1'b0;
    check("t1_freq", int'(gen_frequency), 440);
    for (int t = 0; t <= 354; t++) begin
      if (t <= 32)       e = (8 * t > 255) ? 255 : 8 * t;
      else if (t <= 320) e = 255;
      else               e = 255 - 8 * (t - 320);
      if (e < 0) e = 0;
      check("t1_amp", int'(gen_amplitude), e);
      if (t == 351) check("t1_busy_rel", int'(busy), 1);
      if (t == 353) begin
        check("t1_done", int'(done), 1);
        check("t1_busy_end", int'(busy), 0);
      end
      tick(1);
    end
    check("t1_done_cnt", done_cnt, 1);
    check("t1_freq_idle", int'(gen_frequency), 440);
    check("t1_sb_empty", sb.size(), 0);

    // rest slot then note; zero flag held low -> timeout retune
    do_reset();
    prog(0, 0, 2, 1'b0);
    prog(1, 1000, 1, 1'b1);
    sb.push_back('{1000, 1});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("t2_idx0", int'(note_index), 0);
    tick(1);
    maxa = 0;
    for (int r = 0; r <= 130; r++) begin
      if (r <= 65 && int'(gen_amplitude) > maxa) maxa = int'(gen_amplitude);
      if (r == 63)  check("t2_idx_rest", int'(note_index), 0);
      if (r == 65)  check("t2_idx1", int'(note_index), 1);
      if (r == 129) check("t2_freq_pre", int'(gen_frequency), 0);
      if (r == 130) check("t2_freq_to", int'(gen_frequency), 1000);
      if (r < 130) tick(1);
    end
    check("t2_rest_amp", maxa, 0);
    wait_done(200, "t2_done");
    tick(1);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_sb_empty", sb.size(), 0);

    // looping three slots, then stop during sustain
    do_reset();
    prog(0, 300, 2, 1'b0);
    prog(1, 400, 2, 1'b0);
    prog(2, 500, 2, 1'b1);
    sb.push_back('{300, 0});
    sb.push_back('{400, 1});
    sb.push_back('{500, 2});
    sb.push_back('{300, 0});
    sb.push_back('{400, 1});
    loop_en = 1'b1;
    zero = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (ev_cnt < 5 && n < 2000) begin
      tick(1);
      n++;
    end
    check("t4_events", ev_cnt, 5);
    tick(40);
    check("t4_sustain", int'(gen_amplitude), 255);
    check("t4_idx", int'(note_index), 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t4_rel0", int'(gen_amplitude), 255);
    tick(16);
    check("t4_rel16", int'(gen_amplitude), 127);
    tick(15);
    check("t4_rel31", int'(gen_amplitude), 7);
    check("t4_busy31", int'(busy), 1);
    tick(1);
    check("t4_rel32", int'(gen_amplitude), 0);
    check("t4_idle", int'(busy), 0);
    tick(5);
    check("t4_no_done", done_cnt, 0);
    check("t4_sb_empty", sb.size(), 0);
    loop_en = 1'b0;

    // dur=0 slot skipped, start while busy ignored
    do_reset();
    prog(0, 600, 0, 1'b0);
    prog(1, 700, 1, 1'b1);
    sb.push_back('{700, 1});
    start = 1'b1;
    tick(1);
    check("t5_idx0", int'(note_index), 0);
    tick(1);
    check("t5_skip_amp", int'(gen_amplitude), 0);
    check("t5_skip_busy", int'(busy), 1);
    tick(1);
    check("t5_idx1", int'(note_index), 1);
    tick(4);
    start = 1'b0;
    check("t5_idx_hold", int'(note_index), 1);
    wait_done(200, "t5_done");
    tick(1);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_sb_empty", sb.size(), 0);
    tick(2);
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    check("t5_ss_busy", int'(busy), 0);
    tick(2);
    check("t5_ss_busy2", int'(busy), 0);

    // async reset mid-attack clears outputs and table
    do_reset();
    prog(0, 440, 10, 1'b1);
    prog(3, 900, 5, 1'b1);
    sb.push_back('{440, 0});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(12);
    check("t6_attack", int'(gen_amplitude), 80);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_freq", int'(gen_frequency), 0);
    check("t6_rst_amp", int'(gen_amplitude), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_idx", int'(note_index), 0);
    check("t6_rst_done", int'(done), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("t6_sb_empty", sb.size(), 0);
    done_cnt = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    maxa = 0;
    n = 0;
    while (!done && n < 100) begin
      if (int'(gen_amplitude) > maxa) maxa = int'(gen_amplitude);
      tick(1);
      n++;
    end
    check("t6_done", int'(done), 1);
    check("t6_amp_max", maxa, 0);
    check("t6_freq", int'(gen_frequency), 0);
    check("t6_idx_last", int'(note_index), DEPTH - 1);
    zero = 1'b0;
    tick(3);
    check("t6_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
